shift_unit_seq: RTL and testbench
=================================

Name: shift_unit_seq

Overview:
- Parametrised, multi-cycle shift unit for the CPU execute stage.
- Supersedes the fixed 32-bit, 1-bit arithmetic-right shifter.
- Supports logical left, logical right, arithmetic right and rotate right by a variable amount.
- Shifts up to STEP bit positions per cycle and trades latency for area; operand width and step size are parameters.
- Sits beside the ALU with a start/ready/valid handshake, so the pipeline stalls while it is busy.

Parameters:
- WIDTH, 32, operand and result width in bits (power of two, ≥ 4).
- STEP, 1, maximum bit positions shifted per cycle (power of two, 1 ≤ STEP ≤ WIDTH).
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a shift; sampled only when ready=1.
- data_operandA  input  WIDTH  value to shift; sampled with start.
- shamt  input  SHW  shift amount 0..WIDTH-1; sampled with start.
- mode  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROR; sampled with start.
- ready  output  1  unit idle; a start is accepted this cycle.
- busy  output  1  operation in progress (state != IDLE).
- result_valid  output  1  one-cycle pulse; result is final.
- result  output  WIDTH  shifted value; held until the next accepted start.

Behaviour:
- Single clock domain; reset_n is asynchronous and active-low.
- Reset:
  - state=IDLE, ready=1, busy=0, result_valid=0.
  - result=0, internal count=0, internal latched mode=00.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On start=1 at an edge: the shift register loads data_operandA, count loads shamt, and mode is latched.
  - Next state: DONE if shamt==0, else SHIFT.
- SHIFT:
  - Each cycle, k = min(STEP, count); shift the register by k per the latched mode; count -= k.
  - When count reaches 0 on this edge, next state is DONE.
- DONE:
  - result_valid=1 for exactly one cycle; next state is IDLE.
  - ready=0 in DONE; a start asserted during DONE is ignored.
- Latency: with start in cycle 0 and S = ceil(shamt/STEP), SHIFT occupies cycles 1..S and result_valid is high in cycle S+1.
  - shamt=0 → result_valid in cycle 1, result = operand.
- Mode rules:
  - SLL fills with 0 at the LSB.
  - SRL fills with 0 at the MSB.
  - SRA replicates the original MSB, latched at start, on every step.
  - ROR feeds the LSB(s) into the MSB(s); a full rotation is never requested since shamt < WIDTH.
- result is driven directly from the shift register.
  - Intermediate values are visible while busy but are not valid; consumers use result only on or after result_valid.
- start while busy or in DONE is ignored. No queuing; the operand and shamt inputs are don't-care.
- Inputs are captured only at acceptance. Changing data_operandA, shamt or mode mid-operation has no effect.
- Reset mid-operation aborts immediately to the reset state. result_valid must not pulse for the aborted operation.
- result_valid and ready are never both 1 in the same cycle.
- No combinational path from any input to any output except through state.

Decomposition:
- Shared package cpu_shift_pkg holds:
  - typedef shift_mode_t, with constants SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11.
  - State encoding constants ST_IDLE, ST_SHIFT, ST_DONE.
- One natural sub-module: shift_step_comb.
  - Combinational; inputs are the value, k (0..STEP), mode and the fill bit.
  - Output is the value after one step.
  - Keeps the FSM and datapath separate, and can be unit-tested exhaustively at small WIDTH.

Test Plan:
- WIDTH=32, STEP=1, SRA, operand 0x80000000, shamt 1 → result 0xC0000000, result_valid in cycle 2.
- WIDTH=32, STEP=4, SRA, operand 0xF0000000, shamt 4 → 0xFF000000, valid in cycle 2. Same with shamt 6 → 0xFFC00000, valid in cycle 3 (steps 4 then 2).
- WIDTH=32, STEP=1, SLL, operand 0x00000001, shamt 31 → 0x80000000, valid in cycle 32, busy high cycles 1..32. SRL, operand 0x80000000, shamt 31 → 0x00000001.
- ROR, operand 0x00000003, shamt 1 → 0x80000001. Any mode with shamt 0 and operand 0x12345678 → 0x12345678, valid in cycle 1.
- Second start pulsed in cycles 2 and DONE of a shamt=8, STEP=1 operation → ignored, first result unchanged. A new start in the first IDLE cycle after DONE is accepted.
- reset_n low in cycle 3 of a shamt=10 operation → ready=1, result=0 asynchronously, and no result_valid pulse.

Source files
------------

// File: rtl/cpu_shift_pkg.sv
// Shared definitions for the multi-cycle shift unit: shift modes and FSM state encoding.
package cpu_shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_t;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/shift_step_comb.sv
// One combinational shift step: moves value by k positions (0..WIDTH) in the given mode.
module shift_step_comb
    import cpu_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 6
) (
    input  logic [WIDTH-1:0] value,
    input  logic [KW-1:0]    k,
    input  shift_mode_t      mode,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] sll_v;
    logic [WIDTH-1:0] srl_v;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] wrap_v;
    logic [KW-1:0]    rot_back;

    always_comb begin
        sll_v     = value << k;
        srl_v     = value >> k;
        fill_mask = ~({WIDTH{1'b1}} >> k);
        // k == 0 gives a back-shift of WIDTH, which yields zero: no wrap contribution
        rot_back  = KW'(WIDTH) - k;
        wrap_v    = value << rot_back;
        case (mode)
            SH_SLL:  shifted = sll_v;
            SH_SRL:  shifted = srl_v;
            SH_SRA:  shifted = fill ? (srl_v | fill_mask) : srl_v;
            SH_ROR:  shifted = srl_v | wrap_v;
            default: shifted = value;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit for the execute stage: up to STEP positions per cycle, start/ready/valid handshake.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a new operation; start captures operand/shamt/mode
//   ST_SHIFT | shifting min(STEP, count) positions per cycle
//   ST_DONE  | result final; result_valid pulses for this one cycle
module shift_unit_seq
    import cpu_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       mode,
    output logic             ready,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam int            KW     = SHW + 1;
    localparam logic [KW-1:0] STEP_K = KW'(STEP);

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [SHW-1:0]   count;
    shift_mode_t      mode_q;
    logic             fill_q;
    logic [KW-1:0]    count_ext;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] step_out;

    // count < WIDTH, so k never exceeds count and the narrowed subtraction below is exact
    assign count_ext = {1'b0, count};
    assign k         = (count_ext > STEP_K) ? STEP_K : count_ext;

    shift_step_comb #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .value   (sreg),
        .k       (k),
        .mode    (mode_q),
        .fill    (fill_q),
        .shifted (step_out)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            sreg   <= '0;
            count  <= '0;
            mode_q <= SH_SLL;
            fill_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg   <= data_operandA;
                        count  <= shamt;
                        mode_q <= shift_mode_t'(mode);
                        fill_q <= data_operandA[WIDTH-1];
                        state  <= (shamt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sreg  <= step_out;
                    count <= count - k[SHW-1:0];
                    if (count_ext == k) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready        = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign result_valid = (state == ST_DONE);
    assign result       = sreg;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: two instances (STEP=1 and STEP=4) checked for value, latency and handshake.
module tb_shift_unit_seq;

    logic        clock;
    logic        reset_n;

    logic        start1, start4;
    logic [31:0] data1, data4;
    logic [4:0]  shamt1, shamt4;
    logic [1:0]  mode1, mode4;
    logic        ready1, busy1, valid1;
    logic        ready4, busy4, valid4;
    logic [31:0] result1, result4;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRL = 2'b01;
    localparam logic [1:0] M_SRA = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

    shift_unit_seq #(.WIDTH(32), .STEP(1)) u_s1 (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start1),
        .data_operandA (data1),
        .shamt         (shamt1),
        .mode          (mode1),
        .ready         (ready1),
        .busy          (busy1),
        .result_valid  (valid1),
        .result        (result1)
    );

    shift_unit_seq #(.WIDTH(32), .STEP(4)) u_s4 (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start4),
        .data_operandA (data4),
        .shamt         (shamt4),
        .mode          (mode4),
        .ready         (ready4),
        .busy          (busy4),
        .result_valid  (valid4),
        .result        (result4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start the same operation on both instances in cycle 0 and track them until both have delivered.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] sh,
                          input logic [1:0] md, input logic [31:0] exp,
                          input int lat1, input int lat4);
        int v1c, v4c, n1, n4, busy_cnt, overlap;
        logic [31:0] r1, r4;
        v1c = 0; v4c = 0; n1 = 0; n4 = 0; busy_cnt = 0; overlap = 0;
        r1 = '0; r4 = '0;
        @(negedge clock);
        chk({tag, "_ready1"}, {31'b0, ready1}, 32'd1);
        chk({tag, "_ready4"}, {31'b0, ready4}, 32'd1);
        start1 = 1'b1; data1 = d; shamt1 = sh; mode1 = md;
        start4 = 1'b1; data4 = d; shamt4 = sh; mode4 = md;
        @(posedge clock);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (valid1) begin n1++; if (v1c == 0) v1c = c; r1 = result1; end
            if (valid4) begin n4++; if (v4c == 0) v4c = c; r4 = result4; end
            if (busy1) busy_cnt++;
            if ((valid1 && ready1) || (valid4 && ready4)) overlap++;
            if (v1c != 0 && v4c != 0 && c > v1c && c > v4c) break;
        end
        chk({tag, "_lat1"}, v1c, lat1);
        chk({tag, "_lat4"}, v4c, lat4);
        chk({tag, "_res1"}, r1, exp);
        chk({tag, "_res4"}, r4, exp);
        chk({tag, "_pulses1"}, n1, 32'd1);
        chk({tag, "_pulses4"}, n4, 32'd1);
        chk({tag, "_busy1"}, busy_cnt, lat1);
        chk({tag, "_overlap"}, overlap, 32'd0);
        chk({tag, "_hold1"}, result1, exp);
    endtask

    initial begin
        int n1, vfirst, vlast;
        logic [31:0] rfirst, rlast;

        reset_n = 1'b0;
        start1 = 1'b0; data1 = '0; shamt1 = '0; mode1 = M_SLL;
        start4 = 1'b0; data4 = '0; shamt4 = '0; mode4 = M_SLL;
        #12;
        chk("rst_ready", {31'b0, ready1}, 32'd1);
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        chk("rst_valid", {31'b0, valid1}, 32'd0);
        chk("rst_result1", result1, 32'h0);
        chk("rst_result4", result4, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("sra_1",     32'h8000_0000, 5'd1,  M_SRA, 32'hC000_0000, 2,  2);
        run_op("sra_4",     32'hF000_0000, 5'd4,  M_SRA, 32'hFF00_0000, 5,  2);
        run_op("sra_6",     32'hF000_0000, 5'd6,  M_SRA, 32'hFFC0_0000, 7,  3);
        run_op("sll_31",    32'h0000_0001, 5'd31, M_SLL, 32'h8000_0000, 32, 9);
        run_op("srl_31",    32'h8000_0000, 5'd31, M_SRL, 32'h0000_0001, 32, 9);
        run_op("ror_1",     32'h0000_0003, 5'd1,  M_ROR, 32'h8000_0001, 2,  2);
        run_op("ror_8",     32'h1234_5678, 5'd8,  M_ROR, 32'h7812_3456, 9,  3);
        run_op("sra_pos",   32'h7000_0000, 5'd5,  M_SRA, 32'h0380_0000, 6,  3);
        run_op("sra_31",    32'h8000_0001, 5'd31, M_SRA, 32'hFFFF_FFFF, 32, 9);
        run_op("sll_0",     32'h1234_5678, 5'd0,  M_SLL, 32'h1234_5678, 1,  1);
        run_op("srl_0",     32'h1234_5678, 5'd0,  M_SRL, 32'h1234_5678, 1,  1);
        run_op("sra_0",     32'h1234_5678, 5'd0,  M_SRA, 32'h1234_5678, 1,  1);
        run_op("ror_0",     32'h1234_5678, 5'd0,  M_ROR, 32'h1234_5678, 1,  1);

        // Starts in a SHIFT cycle and in DONE are ignored; a start in the first IDLE cycle is taken.
        @(negedge clock);
        start1 = 1'b1; data1 = 32'h0000_00FF; shamt1 = 5'd8; mode1 = M_SLL;
        @(posedge clock);
        #1;
        start1 = 1'b0;
        n1 = 0; vfirst = 0; vlast = 0; rfirst = '0; rlast = '0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            if (valid1) begin
                n1++;
                if (vfirst == 0) begin vfirst = c; rfirst = result1; end
                vlast = c;
                rlast = result1;
            end
            if (c == 10) begin
                chk("ign_ready10", {31'b0, ready1}, 32'd1);
                chk("ign_hold10", result1, 32'h0000_FF00);
                start1 = 1'b1; data1 = 32'h0000_0100; shamt1 = 5'd4; mode1 = M_SRL;
            end else begin
                start1 = (c == 2) || (c == 9);
                data1 = 32'hDEAD_BEEF; shamt1 = 5'd3; mode1 = M_ROR;
            end
        end
        start1 = 1'b0;
        chk("ign_first_lat", vfirst, 32'd9);
        chk("ign_first_res", rfirst, 32'h0000_FF00);
        chk("ign_second_lat", vlast, 32'd15);
        chk("ign_second_res", rlast, 32'h0000_0010);
        chk("ign_pulses", n1, 32'd2);

        // Reset in cycle 3 of a shamt=10 operation aborts without a result pulse.
        @(negedge clock);
        start1 = 1'b1; data1 = 32'h0000_0001; shamt1 = 5'd10; mode1 = M_SLL;
        start4 = 1'b1; data4 = 32'h0000_0001; shamt4 = 5'd10; mode4 = M_SLL;
        @(posedge clock);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        chk("abort_busy_pre", {31'b0, busy1}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_ready1", {31'b0, ready1}, 32'd1);
        chk("abort_busy1", {31'b0, busy1}, 32'd0);
        chk("abort_result1", result1, 32'h0);
        chk("abort_ready4", {31'b0, ready4}, 32'd1);
        chk("abort_result4", result4, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        n1 = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (valid1 || valid4) n1++;
        end
        chk("abort_no_valid", n1, 32'd0);

        run_op("post_abort", 32'h0000_00F0, 5'd4, M_SRL, 32'h0000_000F, 5, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
